rf_wb_scheduler: RTL and testbench

- Write-back scheduler and hazard scoreboard for the 32x32 MIPS register file (one write port, register 0 hard-wired to zero).
- Arbitrates the single write port between two requesters:
  - port 0: main pipeline write-back (priority).
  - port 1: long-latency unit (mult/div, multi-cycle load).
- Tracks registers with outstanding long-latency writes and reports read-after-write hazards for the decode stage.
- Drives RegWr/RW/busW of the register file from registered outputs.

---
 rtl/rf_wb_scheduler.sv | 141 ++++++++++++++
 tb/tb_rf_wb_scheduler.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/rf_wb_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : rf_wb_scheduler
// Purpose  : Write-port arbiter and RAW hazard scoreboard for the 32x32 MIPS
//            register file (pipeline port 0 has priority, port 1 anti-starve).
// Revision : 1.0  initial release
// ============================================================================
module rf_wb_scheduler #(
    parameter int STARVE_MAX = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        wb0_valid,
    input  logic [4:0]  wb0_rw,
    input  logic [31:0] wb0_data,
    output logic        wb0_ready,
    input  logic        wb1_valid,
    input  logic [4:0]  wb1_rw,
    input  logic [31:0] wb1_data,
    output logic        wb1_ready,
    input  logic        iss_valid,
    input  logic [4:0]  iss_rd,
    output logic        iss_ready,
    input  logic [4:0]  chk_ra,
    input  logic [4:0]  chk_rb,
    output logic        hazard,
    output logic        RegWr,
    output logic [4:0]  RW,
    output logic [31:0] busW,
    output logic [5:0]  pend_cnt
);

    localparam logic [3:0] c_starve_max = 4'(STARVE_MAX);

    logic        regwr_q,  regwr_d;
    logic [4:0]  rw_q,     rw_d;
    logic [31:0] busw_q,   busw_d;
    logic        p1_wr_q,  p1_wr_d;
    logic [3:0]  starve_q, starve_d;
    logic [31:0] busy_q,   busy_d;
    logic [5:0]  pend_q,   pend_d;

    logic w_force;
    logic w_xfer0;
    logic w_xfer1;
    logic w_clr_hit;
    logic w_clr_en;
    logic w_set_en;

    // Grant: a starving port 1 preempts the pipeline for exactly one cycle.
    always_comb begin
        w_force   = wb1_valid && (starve_q == c_starve_max);
        wb0_ready = 1'b1;
        wb1_ready = 1'b0;
        if (w_force) begin
            wb0_ready = 1'b0;
            wb1_ready = 1'b1;
        end else if (!wb0_valid) begin
            wb1_ready = wb1_valid;
        end
        w_xfer0 = wb0_valid && wb0_ready;
        w_xfer1 = wb1_valid && wb1_ready;
    end

    // Busy bit is released only when the port 1 write sits in the output
    // register, so decode keeps stalling through the in-flight cycle.
    always_comb begin
        w_clr_en  = p1_wr_q && (rw_q != 5'd0);
        w_clr_hit = w_clr_en && (rw_q == iss_rd);
        iss_ready = (iss_rd == 5'd0) || !busy_q[iss_rd] || w_clr_hit;
        w_set_en  = iss_valid && iss_ready && (iss_rd != 5'd0);
        hazard    = busy_q[chk_ra] | busy_q[chk_rb];
    end

    always_comb begin
        regwr_d  = 1'b0;
        rw_d     = rw_q;
        busw_d   = busw_q;
        p1_wr_d  = 1'b0;
        starve_d = starve_q;
        busy_d   = busy_q;
        pend_d   = 6'd0;

        if (w_xfer0) begin
            regwr_d = (wb0_rw != 5'd0);
            rw_d    = wb0_rw;
            busw_d  = wb0_data;
        end else if (w_xfer1) begin
            regwr_d = (wb1_rw != 5'd0);
            rw_d    = wb1_rw;
            busw_d  = wb1_data;
            p1_wr_d = 1'b1;
        end

        if (!wb1_valid || w_xfer1) begin
            starve_d = 4'd0;
        end else if (starve_q != c_starve_max) begin
            starve_d = starve_q + 4'd1;
        end

        // Clear before set so a same-register reissue stays marked.
        if (w_clr_en) begin
            busy_d[rw_q] = 1'b0;
        end
        if (w_set_en) begin
            busy_d[iss_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;

        for (int i = 0; i < 32; i++) begin
            pend_d = pend_d + {5'd0, busy_d[i]};
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            regwr_q  <= 1'b0;
            rw_q     <= 5'd0;
            busw_q   <= 32'd0;
            p1_wr_q  <= 1'b0;
            starve_q <= 4'd0;
            busy_q   <= 32'd0;
            pend_q   <= 6'd0;
        end else begin
            regwr_q  <= regwr_d;
            rw_q     <= rw_d;
            busw_q   <= busw_d;
            p1_wr_q  <= p1_wr_d;
            starve_q <= starve_d;
            busy_q   <= busy_d;
            pend_q   <= pend_d;
        end
    end

    assign RegWr    = regwr_q;
    assign RW       = rw_q;
    assign busW     = busw_q;
    assign pend_cnt = pend_q;

endmodule
`default_nettype wire

// File: tb/tb_rf_wb_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_rf_wb_scheduler
// Purpose  : Directed self-checking bench for rf_wb_scheduler (STARVE_MAX=4).
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_rf_wb_scheduler;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        wb0_valid = 1'b0;
    logic [4:0]  wb0_rw = 5'd0;
    logic [31:0] wb0_data = 32'd0;
    logic        wb0_ready;
    logic        wb1_valid = 1'b0;
    logic [4:0]  wb1_rw = 5'd0;
    logic [31:0] wb1_data = 32'd0;
    logic        wb1_ready;
    logic        iss_valid = 1'b0;
    logic [4:0]  iss_rd = 5'd0;
    logic        iss_ready;
    logic [4:0]  chk_ra = 5'd0;
    logic [4:0]  chk_rb = 5'd0;
    logic        hazard;
    logic        RegWr;
    logic [4:0]  RW;
    logic [31:0] busW;
    logic [5:0]  pend_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    rf_wb_scheduler #(.STARVE_MAX(4)) dut (
        .clock(clock), .reset(reset),
        .wb0_valid(wb0_valid), .wb0_rw(wb0_rw), .wb0_data(wb0_data), .wb0_ready(wb0_ready),
        .wb1_valid(wb1_valid), .wb1_rw(wb1_rw), .wb1_data(wb1_data), .wb1_ready(wb1_ready),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready),
        .chk_ra(chk_ra), .chk_rb(chk_rb), .hazard(hazard),
        .RegWr(RegWr), .RW(RW), .busW(busW), .pend_cnt(pend_cnt)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one rising edge; inputs change and outputs are sampled 1ns later.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_regwr", 32'(RegWr), 32'd0);
        chk("rst_rw",    32'(RW),    32'd0);
        chk("rst_busw",  busW,       32'd0);
        chk("rst_pend",  32'(pend_cnt), 32'd0);
        chk("rst_haz",   32'(hazard),   32'd0);
        chk("rst_rdy0",  32'(wb0_ready), 32'd1);
        chk("rst_rdy1",  32'(wb1_ready), 32'd0);
        chk("rst_iss",   32'(iss_ready), 32'd1);
        tick();
        reset = 1'b1;
        tick();

        // Port 0 write to r5, then to r0
        wb0_valid = 1'b1; wb0_rw = 5'd5; wb0_data = 32'h1234_5678;
        #1 chk("p0_ready", 32'(wb0_ready), 32'd1);
        tick();
        wb0_rw = 5'd0; wb0_data = 32'h0000_AAAA;
        chk("p0_regwr", 32'(RegWr), 32'd1);
        chk("p0_rw",    32'(RW),    32'd5);
        chk("p0_busw",  busW,       32'h1234_5678);
        tick();
        wb0_valid = 1'b0;
        chk("p0_r0_regwr", 32'(RegWr), 32'd0);
        chk("p0_r0_busw",  busW,       32'h0000_AAAA);
        tick();
        chk("idle_regwr", 32'(RegWr), 32'd0);
        chk("idle_busw",  busW,       32'h0000_AAAA);

        // Scoreboard: issue r7
        iss_valid = 1'b1; iss_rd = 5'd7;
        #1 chk("iss7_ready", 32'(iss_ready), 32'd1);
        tick();
        iss_valid = 1'b0; chk_ra = 5'd7;
        #1;
        chk("r7_hazard", 32'(hazard),   32'd1);
        chk("r7_pend",   32'(pend_cnt), 32'd1);
        iss_valid = 1'b1;
        #1 chk("iss7_again_ready", 32'(iss_ready), 32'd0);
        tick();
        iss_valid = 1'b0;
        chk("iss7_again_pend", 32'(pend_cnt), 32'd1);

        // wb1 r7, idle arbitration grants port 1 in the same cycle
        wb1_valid = 1'b1; wb1_rw = 5'd7; wb1_data = 32'hDEAD_BEEF;
        #1 chk("p1_idle_ready", 32'(wb1_ready), 32'd1);
        tick();
        wb1_valid = 1'b0;
        #1;
        chk("p1_rdy_novalid", 32'(wb1_ready), 32'd0);
        chk("r7_haz_inflight", 32'(hazard), 32'd1);
        chk("p1_regwr", 32'(RegWr), 32'd1);
        chk("p1_rw",    32'(RW),    32'd7);
        chk("p1_busw",  busW,       32'hDEAD_BEEF);
        chk("iss7_clearing_ready", 32'(iss_ready), 32'd1);
        tick();
        chk("r7_haz_cleared", 32'(hazard),   32'd0);
        chk("r7_pend_cleared", 32'(pend_cnt), 32'd0);
        chk("p1_regwr_drop", 32'(RegWr), 32'd0);

        // Starvation: both ports held, port 1 forced in 5th cycle
        wb0_valid = 1'b1; wb0_rw = 5'd3; wb0_data = 32'h3333_0000;
        wb1_valid = 1'b1; wb1_rw = 5'd4; wb1_data = 32'h4444_0000;
        for (int c = 1; c <= 5; c++) begin
            #1;
            chk($sformatf("starve_c%0d_rdy1", c), 32'(wb1_ready), (c == 5) ? 32'd1 : 32'd0);
            chk($sformatf("starve_c%0d_rdy0", c), 32'(wb0_ready), (c == 5) ? 32'd0 : 32'd1);
            tick();
            if (c == 4) chk("starve_c4_rw", 32'(RW), 32'd3);
        end
        chk("starve_rw",   32'(RW), 32'd4);
        chk("starve_busw", busW,    32'h4444_0000);
        #1;
        chk("starve_after_rdy0", 32'(wb0_ready), 32'd1);
        chk("starve_after_rdy1", 32'(wb1_ready), 32'd0);
        tick();
        wb0_valid = 1'b0; wb1_valid = 1'b0;
        tick();

        // Simultaneous clear and set of r9
        iss_valid = 1'b1; iss_rd = 5'd9;
        tick();
        iss_valid = 1'b0; chk_ra = 5'd0; chk_rb = 5'd9;
        chk("r9_pend", 32'(pend_cnt), 32'd1);
        wb1_valid = 1'b1; wb1_rw = 5'd9; wb1_data = 32'h0000_0009;
        tick();
        wb1_valid = 1'b0;
        iss_valid = 1'b1; iss_rd = 5'd9;
        #1 chk("r9_clrset_ready", 32'(iss_ready), 32'd1);
        tick();
        iss_valid = 1'b0;
        chk("r9_clrset_pend", 32'(pend_cnt), 32'd1);
        chk("r9_clrset_haz",  32'(hazard),   32'd1);

        // Idle arbitration with a fresh long-latency write
        wb1_valid = 1'b1; wb1_rw = 5'd12; wb1_data = 32'hCAFE_F00D;
        #1 chk("p1_r12_ready", 32'(wb1_ready), 32'd1);
        tick();
        wb1_valid = 1'b0;
        chk("p1_r12_busw", busW, 32'hCAFE_F00D);
        chk("p1_r12_rw",   32'(RW), 32'd12);

        // Asynchronous reset mid-traffic
        wb0_valid = 1'b1; wb0_rw = 5'd11; wb0_data = 32'h1111_1111;
        chk_ra = 5'd9;
        tick();
        wb0_valid = 1'b0;
        chk("pre_rst_regwr", 32'(RegWr), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("async_rst_regwr", 32'(RegWr),    32'd0);
        chk("async_rst_pend",  32'(pend_cnt), 32'd0);
        chk("async_rst_haz",   32'(hazard),   32'd0);
        chk("async_rst_busw",  busW,          32'd0);
        tick();
        reset = 1'b1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
